add_sched: RTL and testbench

//  Sequencer for the encapsulation polynomial-add stage. Time-multiplexes one LANES-wide coefficient adder across five jobs:
//  J0 u0=x0+e1_0, J1 u1=x1+e1_1, J2 u2=x2+e1_2, J3 v=y+e2, J4 v=v+msg_poly.

---
 rtl/add_sched.sv | 153 +++++++++++++++
 tb/tb_add_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// Sequencer for the polynomial-add stage: time-multiplexes one LANES-wide adder over
// five jobs (u0..u2, v=y+e2, v+=msg) and drives operand-fetch / write-back strobes.
module add_sched #(
  parameter int N       = 256,
  parameter int LANES   = 4,
  parameter int ADD_LAT = 1,
  parameter int IW      = $clog2(N / LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          dp_ready,
  output logic          rd_en,
  output logic [2:0]    rd_job,
  output logic [IW-1:0] rd_idx,
  output logic          wr_en,
  output logic [2:0]    wr_job,
  output logic [IW-1:0] wr_idx,
  output logic          busy,
  output logic          valid,
  output logic [2:0]    debug_state
);

  localparam int            CHUNKS     = N / LANES;
  localparam logic [IW-1:0] LAST_IDX   = IW'(CHUNKS - 1);
  localparam int            DW         = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ADD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t          r_state;
  logic [2:0]      r_job;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_drain;
  logic            r_v_last;

  state_t          w_state_nxt;
  logic [2:0]      w_job_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [DW-1:0]   w_drain_nxt;
  logic            w_v_last_nxt;
  logic            w_issue;

  logic            r_pipe_en  [ADD_LAT];
  logic [2:0]      r_pipe_job [ADD_LAT];
  logic [IW-1:0]   r_pipe_idx [ADD_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_job    <= 3'd0;
      r_idx    <= '0;
      r_drain  <= '0;
      r_v_last <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_job    <= w_job_nxt;
      r_idx    <= w_idx_nxt;
      r_drain  <= w_drain_nxt;
      r_v_last <= w_v_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_job_nxt    = r_job;
    w_idx_nxt    = r_idx;
    w_drain_nxt  = r_drain;
    w_v_last_nxt = r_v_last;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt  = S_ISSUE;
          w_job_nxt    = 3'd0;
          w_idx_nxt    = '0;
          w_v_last_nxt = 1'b0;
        end
      end
      S_ISSUE: begin
        w_issue = dp_ready;
        if (dp_ready) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            // v is read back by J4, so both v-producing jobs end in a drain
            if (r_job == 3'd3) begin
              w_state_nxt = S_DRAIN;
              w_job_nxt   = 3'd4;
              w_drain_nxt = '0;
            end else if (r_job == 3'd4) begin
              w_state_nxt  = S_DRAIN;
              w_drain_nxt  = '0;
              w_v_last_nxt = 1'b1;
            end else begin
              w_job_nxt = r_job + 3'd1;
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_state_nxt = r_v_last ? S_DONE : S_ISSUE;
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write-back delay line: runs every cycle so writes land exactly ADD_LAT after issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        r_pipe_en[i]  <= 1'b0;
        r_pipe_job[i] <= 3'd0;
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_en[0]  <= w_issue;
      r_pipe_job[0] <= r_job;
      r_pipe_idx[0] <= r_idx;
      for (int i = 1; i < ADD_LAT; i++) begin
        r_pipe_en[i]  <= r_pipe_en[i-1];
        r_pipe_job[i] <= r_pipe_job[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  assign rd_en       = w_issue;
  assign rd_job      = r_job;
  assign rd_idx      = r_idx;
  assign wr_en       = r_pipe_en[ADD_LAT-1];
  assign wr_job      = r_pipe_job[ADD_LAT-1];
  assign wr_idx      = r_pipe_idx[ADD_LAT-1];
  assign busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign valid       = (r_state == S_DONE);
  assign debug_state = r_state;

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched: default instance plus an ADD_LAT=3 instance on shared inputs.
module tb_add_sched;
  localparam int CH = 64;

  logic clk, rst, enable, dp_ready;
  logic       rd_en, wr_en, busy, valid;
  logic [2:0] rd_job, wr_job, debug_state;
  logic [5:0] rd_idx, wr_idx;
  logic       rd_en3, wr_en3, busy3, valid3;
  logic [2:0] rd_job3, wr_job3, debug_state3;
  logic [5:0] rd_idx3, wr_idx3;

  add_sched #(.N(256), .LANES(4), .ADD_LAT(1), .IW(6)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .dp_ready(dp_ready),
    .rd_en(rd_en), .rd_job(rd_job), .rd_idx(rd_idx),
    .wr_en(wr_en), .wr_job(wr_job), .wr_idx(wr_idx),
    .busy(busy), .valid(valid), .debug_state(debug_state));

  add_sched #(.N(256), .LANES(4), .ADD_LAT(3), .IW(6)) u_dut3 (
    .clk(clk), .rst(rst), .enable(enable), .dp_ready(dp_ready),
    .rd_en(rd_en3), .rd_job(rd_job3), .rd_idx(rd_idx3),
    .wr_en(wr_en3), .wr_job(wr_job3), .wr_idx(wr_idx3),
    .busy(busy3), .valid(valid3), .debug_state(debug_state3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rd_en; int rd_job; int rd_idx;
    bit wr_en; int wr_job; int wr_idx;
    bit busy;  bit valid;  int st;
  } obs_t;

  typedef struct {
    int k; int st;
    bit rd; int rj; int ri;
    bit wr; int wj; int wi;
    bit bz; bit vl;
  } vec_t;

  obs_t lg  [0:1023];
  obs_t lg3 [0:1023];
  bit   dpl [0:1023];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic log_now(input int k);
    lg[k]  = '{rd_en, int'(rd_job), int'(rd_idx), wr_en, int'(wr_job), int'(wr_idx),
               busy, valid, int'(debug_state)};
    lg3[k] = '{rd_en3, int'(rd_job3), int'(rd_idx3), wr_en3, int'(wr_job3), int'(wr_idx3),
               busy3, valid3, int'(debug_state3)};
    dpl[k] = dp_ready;
  endtask

  task automatic sample(input int k, input logic dp);
    @(negedge clk);
    dp_ready = dp;
    #1;
    log_now(k);
  endtask

  task automatic start_run();
    @(negedge clk);
    enable   = 1'b1;
    dp_ready = 1'b1;
    #1;
    log_now(0);
  endtask

  task automatic check_writes(input string name, input int k0, input int k1, input bit sel);
    int n = 0;
    int bad = 0;
    obs_t o;
    for (int k = k0; k <= k1; k++) begin
      o = sel ? lg3[k] : lg[k];
      if (o.wr_en) begin
        if (o.wr_job != n / CH || o.wr_idx != n % CH) bad++;
        n++;
      end
    end
    chk({name, "_wr_cnt"}, n, 5 * CH);
    chk({name, "_wr_order"}, bad, 0);
  endtask

  task automatic check_issues(input string name, input int k0, input int k1);
    int n = 0;
    int bad = 0;
    int nodp = 0;
    for (int k = k0; k <= k1; k++) begin
      if (lg[k].rd_en) begin
        if (lg[k].rd_job != n / CH || lg[k].rd_idx != n % CH) bad++;
        if (!dpl[k]) nodp++;
        n++;
      end
    end
    chk({name, "_rd_cnt"}, n, 5 * CH);
    chk({name, "_rd_order"}, bad, 0);
    chk({name, "_rd_without_ready"}, nodp, 0);
  endtask

  task automatic check_lag(input string name, input int k0, input int k1, input int lat,
                           input bit sel);
    int bad = 0;
    obs_t a, b;
    for (int k = k0; k <= k1; k++) begin
      a = sel ? lg3[k] : lg[k];
      b = sel ? lg3[k+lat] : lg[k+lat];
      if (a.rd_en && !(b.wr_en && b.wr_job == a.rd_job && b.wr_idx == a.rd_idx)) bad++;
    end
    chk(name, bad, 0);
  endtask

  function automatic vec_t mk(int k, int st, bit rd, int rj, int ri,
                              bit wr, int wj, int wi, bit bz, bit vl);
    vec_t v;
    v = '{k, st, rd, rj, ri, wr, wj, wi, bz, vl};
    return v;
  endfunction

  vec_t tv [12];
  int   seq;
  int   prev;

  initial begin
    tv[0]  = mk(  0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
    tv[1]  = mk(  1, 1, 1, 0, 0,  0, 0, 0,  1, 0);
    tv[2]  = mk(  2, 1, 1, 0, 1,  1, 0, 0,  1, 0);
    tv[3]  = mk( 65, 1, 1, 1, 0,  1, 0, 63, 1, 0);
    tv[4]  = mk(256, 1, 1, 3, 63, 1, 3, 62, 1, 0);
    tv[5]  = mk(257, 2, 0, 0, 0,  1, 3, 63, 1, 0);
    tv[6]  = mk(258, 1, 1, 4, 0,  0, 0, 0,  1, 0);
    tv[7]  = mk(259, 1, 1, 4, 1,  1, 4, 0,  1, 0);
    tv[8]  = mk(321, 1, 1, 4, 63, 1, 4, 62, 1, 0);
    tv[9]  = mk(322, 2, 0, 0, 0,  1, 4, 63, 1, 0);
    tv[10] = mk(323, 3, 0, 0, 0,  0, 0, 0,  0, 1);
    tv[11] = mk(330, 3, 0, 0, 0,  0, 0, 0,  0, 1);

    // Reset state
    rst = 1'b0; enable = 1'b0; dp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    log_now(0);
    chk("rst_state",  lg[0].st, 0);
    chk("rst_rd_en",  lg[0].rd_en, 0);
    chk("rst_rd_job", lg[0].rd_job, 0);
    chk("rst_rd_idx", lg[0].rd_idx, 0);
    chk("rst_wr_en",  lg[0].wr_en, 0);
    chk("rst_wr_job", lg[0].wr_job, 0);
    chk("rst_wr_idx", lg[0].wr_idx, 0);
    chk("rst_busy",   lg[0].busy, 0);
    chk("rst_valid",  lg[0].valid, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full run, dp_ready tied high, enable held
    start_run();
    for (int k = 1; k <= 330; k++) sample(k, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_state", tv[i].k), lg[tv[i].k].st, tv[i].st);
      chk($sformatf("v%0d_rd_en", tv[i].k), lg[tv[i].k].rd_en, tv[i].rd);
      chk($sformatf("v%0d_wr_en", tv[i].k), lg[tv[i].k].wr_en, tv[i].wr);
      chk($sformatf("v%0d_busy",  tv[i].k), lg[tv[i].k].busy, tv[i].bz);
      chk($sformatf("v%0d_valid", tv[i].k), lg[tv[i].k].valid, tv[i].vl);
      if (tv[i].rd) begin
        chk($sformatf("v%0d_rd_job", tv[i].k), lg[tv[i].k].rd_job, tv[i].rj);
        chk($sformatf("v%0d_rd_idx", tv[i].k), lg[tv[i].k].rd_idx, tv[i].ri);
      end
      if (tv[i].wr) begin
        chk($sformatf("v%0d_wr_job", tv[i].k), lg[tv[i].k].wr_job, tv[i].wj);
        chk($sformatf("v%0d_wr_idx", tv[i].k), lg[tv[i].k].wr_idx, tv[i].wi);
      end
    end
    check_issues("run1", 1, 330);
    check_writes("run1", 0, 330, 1'b0);
    check_lag("run1_lag1", 0, 329, 1, 1'b0);
    seq = 0; prev = -1;
    for (int k = 0; k <= 330; k++) begin
      if (lg[k].st != prev) begin
        seq  = seq * 10 + lg[k].st;
        prev = lg[k].st;
      end
    end
    chk("run1_state_seq", seq, 12123);

    // ADD_LAT=3 instance on the same stimulus
    chk("lat3_drain_a0", lg3[257].st, 2);
    chk("lat3_drain_a2", lg3[259].st, 2);
    chk("lat3_j4_first", lg3[260].rd_en && lg3[260].rd_job == 4 && lg3[260].rd_idx == 0, 1);
    chk("lat3_drain_b0", lg3[324].st, 2);
    chk("lat3_drain_b2", lg3[326].st, 2);
    chk("lat3_valid_326", lg3[326].valid, 0);
    chk("lat3_valid_327", lg3[327].valid, 1);
    check_lag("lat3_lag3", 0, 327, 3, 1'b1);
    check_writes("lat3", 0, 330, 1'b1);

    // Leaving DONE: valid holds in the cycle enable drops, clears on the next
    @(negedge clk); enable = 1'b0; #1;
    chk("done_valid_hold", valid, 1);
    @(negedge clk); #1;
    chk("done_exit_valid", valid, 0);
    chk("done_exit_state", debug_state, 0);

    // dp_ready toggling 1010...: 255 + 63 stall cycles in ISSUE
    start_run();
    for (int k = 1; k <= 660; k++) sample(k, (k % 2) == 1);
    check_issues("tog", 1, 660);
    check_writes("tog", 0, 660, 1'b0);
    chk("tog_valid_640", lg[640].valid, 0);
    chk("tog_valid_641", lg[641].valid, 1);
    @(negedge clk); enable = 1'b0; dp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // enable dropped mid-run: run still completes, then returns to IDLE
    start_run();
    for (int k = 1; k <= 340; k++) begin
      if (k == 50) enable = 1'b0;
      sample(k, 1'b1);
    end
    check_issues("endrop", 1, 340);
    chk("endrop_valid_323", lg[323].valid, 1);
    chk("endrop_valid_324", lg[324].valid, 0);
    chk("endrop_state_324", lg[324].st, 0);

    // Synchronous reset pulse mid-run with enable held high
    start_run();
    for (int k = 1; k <= 100; k++) sample(k, 1'b1);
    rst = 1'b0;
    sample(101, 1'b1);
    rst = 1'b1;
    for (int k = 102; k <= 431; k++) sample(k, 1'b1);
    chk("mrst_state", lg[101].st, 0);
    chk("mrst_rd_en", lg[101].rd_en, 0);
    chk("mrst_wr_en", lg[101].wr_en, 0);
    chk("mrst_outs",  lg[101].rd_job + lg[101].rd_idx + lg[101].wr_job + lg[101].wr_idx, 0);
    chk("mrst_busy",  lg[101].busy, 0);
    chk("mrst_lat3_stray_wr",
        int'(lg3[101].wr_en) + int'(lg3[102].wr_en) + int'(lg3[103].wr_en) + int'(lg3[104].wr_en), 0);
    chk("mrst_restart", lg[102].rd_en && lg[102].rd_job == 0 && lg[102].rd_idx == 0, 1);
    check_writes("mrst", 101, 431, 1'b0);
    check_writes("mrst_lat3", 101, 431, 1'b1);
    chk("mrst_valid_423", lg[423].valid, 0);
    chk("mrst_valid_424", lg[424].valid, 1);

    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
